// File: rtl/ram_responder_if.sv
// ram_responder_if: request/acknowledge bundle between cache (master)
// and its backing RAM responder (slave).
interface ram_responder_if;
    logic        Schreiben;
    logic        Lesen;
    logic [31:0] Adresse;
    logic [31:0] SchreibDaten;
    logic [31:0] LesDaten;
    logic        DatenGeschrieben;
    logic        DatenGelesen;
    logic        Belegt;

    modport master (
        output Schreiben, Lesen, Adresse, SchreibDaten,
        input  LesDaten, DatenGeschrieben, DatenGelesen, Belegt
    );

    modport slave (
        input  Schreiben, Lesen, Adresse, SchreibDaten,
        output LesDaten, DatenGeschrieben, DatenGelesen, Belegt
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM backing store with wait states.
// Optional RAM_RESPONDER_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra waits.
module ram_responder #(
    parameter int ADDRBITS   = 12,
    parameter int WAITCYCLES = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    ram_responder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WAIT = 3'b010,
        S_ACK  = 3'b100
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [8:0]    cnt;
    logic [8:0]    cnt_nxt;
    logic [8:0]    wait_len;
    logic          op_wr;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          req;
    logic          cur_wr;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_data;
    logic          in_range;
    logic          enter_ack;
    logic [ADDRBITS-1:0] idx;

    logic [31:0] mem [0:(1<<ADDRBITS)-1];

    assign req = bus.Schreiben | bus.Lesen;

`ifdef RAM_RESPONDER_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    // Advance the wait-jitter LFSR once per accepted request
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr <= 8'hA5;
        end else if (state == S_IDLE && req) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_len = 9'(WAITCYCLES) + {7'd0, lfsr[1:0]};
`else
    assign wait_len = 9'(WAITCYCLES);
`endif

    // In IDLE the live request is used so a zero-wait access completes at once
    assign cur_wr   = state[0] ? bus.Schreiben    : op_wr;
    assign cur_addr = state[0] ? bus.Adresse      : addr_q;
    assign cur_data = state[0] ? bus.SchreibDaten : data_q;
    assign in_range = (cur_addr[31:ADDRBITS] == '0);
    assign idx      = cur_addr[ADDRBITS-1:0];
    assign enter_ack = (state_nxt == S_ACK);

    // State and wait counter registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> WAIT (counted) -> ACK (one cycle) -> IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (1'b1)
            state[0]: begin
                if (req) begin
                    cnt_nxt   = wait_len;
                    state_nxt = (wait_len == '0) ? S_ACK : S_WAIT;
                end
            end
            state[1]: begin
                cnt_nxt = cnt - 9'd1;
                if (cnt <= 9'd1) begin
                    state_nxt = S_ACK;
                end
            end
            state[2]: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; write wins when both are raised
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            op_wr  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state == S_IDLE && req) begin
            op_wr  <= bus.Schreiben;
            addr_q <= bus.Adresse;
            data_q <= bus.SchreibDaten;
        end
    end

    // Registered outputs: ack pulses, busy flag and held read data
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.LesDaten         <= '0;
            bus.DatenGeschrieben <= 1'b0;
            bus.DatenGelesen     <= 1'b0;
            bus.Belegt           <= 1'b0;
        end else begin
            bus.DatenGeschrieben <= enter_ack & cur_wr;
            bus.DatenGelesen     <= enter_ack & ~cur_wr;
            bus.Belegt           <= (state_nxt != S_IDLE);
            if (enter_ack && !cur_wr) begin
                bus.LesDaten <= in_range ? mem[idx] : 32'h0;
            end
        end
    end

    // Memory write on the edge entering ACK; out-of-range writes are dropped
    always_ff @(posedge Clock) begin
        if (Reset && enter_ack && cur_wr && in_range) begin
            mem[idx] <= cur_data;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed stimulus with a queue-based scoreboard
// and an independent ack monitor.
module tb_ram_responder;

`ifdef RAM_RESPONDER_RANDOM_WAIT_EN
    localparam int W = 0;
`else
    localparam int W = 2;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    logic Clock;
    logic Reset;
    ram_responder_if bus ();

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] last_rd;
    int          lat;

    ram_responder #(
        .ADDRBITS   (12),
        .WAITCYCLES (W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest expected transaction
    always @(negedge Clock) begin
        exp_t e;
        if (bus.DatenGeschrieben || bus.DatenGelesen) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got DG=%b DL=%b expected none",
                         bus.DatenGeschrieben, bus.DatenGelesen);
            end else begin
                e = sb.pop_front();
                chk("ack_wr", {31'b0, bus.DatenGeschrieben}, {31'b0, e.wr});
                chk("ack_rd", {31'b0, bus.DatenGelesen}, {31'b0, ~e.wr});
                if (e.wr) begin
                    chk("lesdaten_hold", bus.LesDaten, last_rd);
                end else begin
                    chk("read_data", bus.LesDaten, e.data);
                    last_rd = e.data;
                end
            end
        end
    end

    // Called at a negedge with the responder idle; returns at a negedge
    task automatic xfer(input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, output int l);
        exp_t e;
        logic got;
        logic busy_ok;
        e.wr   = wr;
        e.data = exp_data;
        sb.push_back(e);
        bus.Schreiben    = wr;
        bus.Lesen        = rd;
        bus.Adresse      = a;
        bus.SchreibDaten = d;
        l       = 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        while (!got && l < 600) begin
            @(negedge Clock);
            l++;
            if (bus.DatenGeschrieben || bus.DatenGelesen) begin
                got = 1'b1;
            end else begin
                if (!bus.Belegt) busy_ok = 1'b0;
                bus.Adresse      = ~a;
                bus.SchreibDaten = ~d;
            end
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        chk("busy_in_wait", {31'b0, busy_ok}, 32'd1);
`ifdef RAM_RESPONDER_RANDOM_WAIT_EN
        chk("latency_range", {31'b0, (l >= W + 1 && l <= W + 4)}, 32'd1);
`else
        chk("latency", 32'(l), 32'(W + 1));
`endif
        bus.Schreiben = 1'b0;
        bus.Lesen     = 1'b0;
        @(negedge Clock);
        chk("ack_single", {31'b0, bus.DatenGeschrieben | bus.DatenGelesen}, 32'd0);
        chk("idle_gap", {31'b0, bus.Belegt}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset   = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        logic [31:0] pre [4];
        n_checks = 0;
        n_fail   = 0;
        last_rd  = '0;
        Reset    = 1'b0;
        bus.Schreiben    = 1'b0;
        bus.Lesen        = 1'b0;
        bus.Adresse      = '0;
        bus.SchreibDaten = '0;
        pre[0] = 32'hA0000020;
        pre[1] = 32'hB1111121;
        pre[2] = 32'hC2222222;
        pre[3] = 32'hD3333323;

        repeat (2) @(negedge Clock);
        chk("rst_lesdaten", bus.LesDaten, 32'h0);
        chk("rst_dg", {31'b0, bus.DatenGeschrieben}, 32'd0);
        chk("rst_dl", {31'b0, bus.DatenGelesen}, 32'd0);
        chk("rst_belegt", {31'b0, bus.Belegt}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        xfer(1, 0, 32'h10, 32'h12345678, 32'h0, lat);
        xfer(0, 1, 32'h10, 32'h0, 32'h12345678, lat);

        for (int i = 0; i < 4; i++)
            xfer(1, 0, 32'h20 + 32'(i), pre[i], 32'h0, lat);
        for (int i = 0; i < 4; i++)
            xfer(0, 1, 32'h20 + 32'(i), 32'h0, pre[i], lat);

        xfer(1, 1, 32'h05, 32'hCAFEBABE, 32'h0, lat);
        xfer(0, 1, 32'h05, 32'h0, 32'hCAFEBABE, lat);

        xfer(1, 0, 32'h000, 32'hA5A50000, 32'h0, lat);
        xfer(1, 0, 32'h00100000, 32'hFFFFFFFF, 32'h0, lat);
        xfer(0, 1, 32'h00100000, 32'h0, 32'h0, lat);
        xfer(0, 1, 32'h000, 32'h0, 32'hA5A50000, lat);

`ifndef RAM_RESPONDER_RANDOM_WAIT_EN
        xfer(1, 0, 32'h7, 32'h11110007, 32'h0, lat);
        bus.Schreiben    = 1'b1;
        bus.Adresse      = 32'h7;
        bus.SchreibDaten = 32'hDEADBEEF;
        @(negedge Clock);
        chk("wait_belegt", {31'b0, bus.Belegt}, 32'd1);
        Reset   = 1'b0;
        last_rd = '0;
        #1;
        chk("abort_belegt", {31'b0, bus.Belegt}, 32'd0);
        chk("abort_dg", {31'b0, bus.DatenGeschrieben}, 32'd0);
        chk("abort_lesdaten", bus.LesDaten, 32'h0);
        bus.Schreiben = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        xfer(0, 1, 32'h7, 32'h0, 32'h11110007, lat);
`else
        begin
            int          lat_a [16];
            int          lb;
            logic [7:0]  m;
            do_reset();
            m = 8'hA5;
            for (int i = 0; i < 16; i++) begin
                xfer(0, 1, 32'h20 + 32'(i % 4), 32'h0, pre[i % 4], lat_a[i]);
                chk("lfsr_latency", 32'(lat_a[i]), 32'(W + 1) + {30'b0, m[1:0]});
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            end
            do_reset();
            for (int i = 0; i < 16; i++) begin
                xfer(0, 1, 32'h20 + 32'(i % 4), 32'h0, pre[i % 4], lb);
                chk("lfsr_repeat", 32'(lb), 32'(lat_a[i]));
            end
        end
`endif

        repeat (2) @(negedge Clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
